// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule definitions.
//   key_len_t  - key length selector (128/192/256/reserved)
//   nk_of      - key length in 32-bit words (Nk)
//   nr_of      - number of rounds (Nr)
//   key_bits_of- key size in bits (reserved maps above any legal size)
//   sbox       - AES forward S-box byte substitution
//   xtime      - multiply by x in GF(2^8), AES polynomial 0x11B
package aes_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        KL128   = 2'd0,
        KL192   = 2'd1,
        KL256   = 2'd2,
        KL_RSVD = 2'd3
    } key_len_t;

    function automatic logic [3:0] nk_of(input key_len_t kl);
        case (kl)
            KL192:   return 4'd6;
            KL256:   return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_t kl);
        case (kl)
            KL192:   return 4'd12;
            KL256:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic int unsigned key_bits_of(input key_len_t kl);
        case (kl)
            KL128:   return 128;
            KL192:   return 192;
            KL256:   return 256;
            default: return 512;
        endcase
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// aes_sbox_word: combinational SubWord, S-box applied to each of four bytes.
//   word     in  32  input word
//   sub_word out 32  byte-wise S-box substitution of word
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub_word
);

    assign sub_word = {sbox(word[31:24]), sbox(word[23:16]),
                       sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/key_expand_multi.sv
// key_expand_multi: iterative AES-128/192/256 key-schedule engine.
// Loads Nk key words over a valid/ready handshake, then generates one
// schedule word per cycle into internal storage and serves any round key
// word through a random-access read port once complete.
//   clk, reset_n        clock, asynchronous active-low reset
//   start, key_len      begin a new load (key_len sampled on start)
//   key_word/valid/ready key input handshake (first word = w[0])
//   rd_round, rd_word   read address (round 0..Nr, word 0 = MS word)
//   rd_key              selected schedule word (0 unless done and in range)
//   busy, done, err     status; err is a one-cycle pulse on bad key_len
module key_expand_multi
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256,
    parameter bit          REG_RD_OUT   = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic [WORD_W-1:0] key_word,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [3:0]        rd_round,
    input  logic [1:0]        rd_word,
    output logic [WORD_W-1:0] rd_key,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned NR_MAX = MAX_KEY_BITS / 32 + 6;
    localparam int unsigned DEPTH  = 4 * (NR_MAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

    state_t            state, state_nxt;
    key_len_t          kl_q, kl_req;
    logic [5:0]        idx_q;
    logic [2:0]        phase_q;
    logic [7:0]        rcon_q;
    logic [WORD_W-1:0] w_prev_q;
    logic              err_q;
    logic [WORD_W-1:0] w_mem [DEPTH];

    logic [3:0]        nk, nr;
    logic [2:0]        nk_m1;
    logic [5:0]        last_idx, back_idx, rd_idx;
    logic              start_ok, start_bad, wr_en, rd_hit;
    logic [WORD_W-1:0] sbox_in, sbox_out, t_word, wr_data, rd_val;

    assign kl_req    = key_len_t'(key_len);
    assign start_ok  = start && (kl_req != KL_RSVD) && (key_bits_of(kl_req) <= MAX_KEY_BITS);
    assign start_bad = start && !start_ok;

    assign nk       = nk_of(kl_q);
    assign nr       = nr_of(kl_q);
    assign nk_m1    = 3'(nk - 4'd1);
    assign last_idx = {nr, 2'b11};

    // w[i-1] is kept in w_prev_q so storage needs only one expansion read.
    assign back_idx = (state == EXPAND) ? (idx_q - {2'b00, nk}) : '0;

    assign sbox_in = (phase_q == 3'd0) ? {w_prev_q[23:0], w_prev_q[31:24]} : w_prev_q;

    aes_sbox_word u_sbox_word (
        .word     (sbox_in),
        .sub_word (sbox_out)
    );

    always_comb begin
        t_word = w_prev_q;
        if (phase_q == 3'd0)
            t_word = sbox_out ^ {rcon_q, 24'h000000};
        else if (nk == 4'd8 && phase_q == 3'd4)
            t_word = sbox_out;
    end

    assign wr_en   = ((state == LOAD && key_valid) || state == EXPAND) && !start_ok;
    assign wr_data = (state == LOAD) ? key_word : (w_mem[back_idx] ^ t_word);

    always_comb begin
        state_nxt = state;
        if (start_ok) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD:    if (key_valid && idx_q == {3'b000, nk_m1}) state_nxt = EXPAND;
                EXPAND:  if (idx_q == last_idx) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            kl_q     <= KL128;
            idx_q    <= '0;
            phase_q  <= '0;
            rcon_q   <= 8'h01;
            w_prev_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= start_bad;
            if (start_ok) begin
                kl_q    <= kl_req;
                idx_q   <= '0;
                phase_q <= '0;
                rcon_q  <= 8'h01;
            end else if (wr_en) begin
                idx_q    <= idx_q + 6'd1;
                w_prev_q <= wr_data;
                if (state == EXPAND) begin
                    phase_q <= (phase_q == nk_m1) ? 3'd0 : phase_q + 3'd1;
                    if (phase_q == 3'd0)
                        rcon_q <= xtime(rcon_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            w_mem[idx_q] <= wr_data;
    end

    assign rd_hit = (state == DONE) && (rd_round <= nr);
    assign rd_idx = rd_hit ? {rd_round, rd_word} : '0;
    assign rd_val = rd_hit ? w_mem[rd_idx] : '0;

    if (REG_RD_OUT) begin : g_rd_reg
        logic [WORD_W-1:0] rd_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) rd_q <= '0;
            else          rd_q <= rd_val;
        end
        assign rd_key = rd_q;
    end else begin : g_rd_comb
        assign rd_key = rd_val;
    end

    assign key_ready = (state == LOAD);
    assign busy      = (state == LOAD) || (state == EXPAND);
    assign done      = (state == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_key_expand_multi.sv
// tb_key_expand_multi: directed self-checking bench for key_expand_multi
// using FIPS-197 key expansion vectors for all three key lengths.
module tb_key_expand_multi;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  key_len;
    logic [31:0] key_word;
    logic        key_valid;
    logic        key_ready;
    logic [3:0]  rd_round;
    logic [1:0]  rd_word;
    logic [31:0] rd_key;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cycles;

    logic [31:0] key_buf [8];
    logic [31:0] k128 [8] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
                              32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] k192 [8] = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                              32'h62f8ead2, 32'h522c6b7b, 32'h0, 32'h0};
    logic [31:0] k256 [8] = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                              32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};

    key_expand_multi #(.MAX_KEY_BITS(256), .REG_RD_OUT(1'b0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .key_len   (key_len),
        .key_word  (key_word),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rd_round  (rd_round),
        .rd_word   (rd_word),
        .rd_key    (rd_key),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [3:0] r, input logic [1:0] w,
                              input logic [31:0] exp);
        rd_round = r;
        rd_word  = w;
        #1;
        check(tag, rd_key, exp);
    endtask

    // Pulses start, then feeds n words from key_buf, optionally with idle gaps.
    task automatic load_key(input logic [1:0] kl, input int n, input bit gaps);
        start   = 1'b1;
        key_len = kl;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                key_valid = 1'b0;
                repeat ($urandom_range(0, 3)) step();
            end
            key_valid = 1'b1;
            key_word  = key_buf[i];
            step();
        end
        key_valid = 1'b0;
        key_word  = '0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        key_len   = 2'd0;
        key_word  = '0;
        key_valid = 1'b0;
        rd_round  = '0;
        rd_word   = '0;
        #1;
        check("rst_key_ready", {31'b0, key_ready}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_done",      {31'b0, done},      32'd0);
        check("rst_err",       {31'b0, err},       32'd0);
        check("rst_rd_key",    rd_key,             32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        // AES-128
        key_buf = k128;
        load_key(2'd0, 4, 1'b0);
        check("busy_expand128", {31'b0, busy}, 32'd1);
        wait_done(cycles);
        check("lat128", cycles, 32'd40);
        check("busy_done128", {31'b0, busy}, 32'd0);
        read_check("w0_128",  4'd0,  2'd0, 32'h2b7e1516);
        read_check("w4_128",  4'd1,  2'd0, 32'ha0fafe17);
        read_check("w5_128",  4'd1,  2'd1, 32'h88542cb1);
        read_check("w43_128", 4'd10, 2'd3, 32'hb6630ca6);
        read_check("oor_128", 4'd11, 2'd0, 32'h0);

        // Reserved key length while done: err pulse only
        key_valid = 1'b1;
        start     = 1'b1;
        key_len   = 2'd3;
        step();
        start     = 1'b0;
        key_valid = 1'b0;
        check("err_pulse",     {31'b0, err},       32'd1);
        check("err_busy",      {31'b0, busy},      32'd0);
        check("err_key_ready", {31'b0, key_ready}, 32'd0);
        check("err_done_kept", {31'b0, done},      32'd1);
        step();
        check("err_cleared", {31'b0, err},  32'd0);
        check("err_done_2",  {31'b0, done}, 32'd1);
        read_check("w43_after_err", 4'd10, 2'd3, 32'hb6630ca6);

        // AES-192 with gaps on key_valid
        key_buf = k192;
        load_key(2'd1, 6, 1'b1);
        wait_done(cycles);
        check("lat192", cycles, 32'd46);
        read_check("w6_192",  4'd1,  2'd2, 32'hfe0c91f7);
        read_check("w51_192", 4'd12, 2'd3, 32'h01002202);
        read_check("oor_192", 4'd13, 2'd0, 32'h0);

        // AES-256
        key_buf = k256;
        load_key(2'd2, 8, 1'b0);
        wait_done(cycles);
        check("lat256", cycles, 32'd52);
        read_check("w8_256",  4'd2,  2'd0, 32'h9ba35411);
        read_check("w12_256", 4'd3,  2'd0, 32'ha8b09c1a);
        read_check("w59_256", 4'd14, 2'd3, 32'h706c631e);
        read_check("oor_256", 4'd15, 2'd3, 32'h0);

        // Abort mid-EXPAND of AES-128, restart with AES-256
        key_buf = k128;
        load_key(2'd0, 4, 1'b0);
        check("abort_done_clr", {31'b0, done}, 32'd0);
        repeat (10) step();
        check("abort_busy", {31'b0, busy}, 32'd1);
        key_buf = k256;
        load_key(2'd2, 8, 1'b1);
        check("abort_done_low", {31'b0, done}, 32'd0);
        wait_done(cycles);
        check("abort_lat256", cycles, 32'd52);
        read_check("abort_w8",  4'd2,  2'd0, 32'h9ba35411);
        read_check("abort_w59", 4'd14, 2'd3, 32'h706c631e);
        read_check("abort_oor", 4'd15, 2'd0, 32'h0);

        // Asynchronous reset during EXPAND
        key_buf = k128;
        load_key(2'd0, 4, 1'b0);
        repeat (5) step();
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rd_round = 4'd1;
        rd_word  = 2'd0;
        reset_n  = 1'b0;
        #1;
        check("arst_done",      {31'b0, done},      32'd0);
        check("arst_busy",      {31'b0, busy},      32'd0);
        check("arst_key_ready", {31'b0, key_ready}, 32'd0);
        check("arst_rd_key",    rd_key,             32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("post_rst_idle", {31'b0, busy}, 32'd0);
        load_key(2'd0, 4, 1'b0);
        wait_done(cycles);
        check("rerun_lat128", cycles, 32'd40);
        read_check("rerun_w4",  4'd1,  2'd0, 32'ha0fafe17);
        read_check("rerun_w43", 4'd10, 2'd3, 32'hb6630ca6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
